// File: rtl/idct_pkg.sv
// Shared definitions for the 2-D IDCT controller: word and block sizes,
// the controller state encoding and the level-shift constants.
// The level-shift option is selected with the macro IDCT_CTRL_LEVEL_SHIFT_EN.
package idct_pkg;

    localparam int W           = 32;   // coefficient / sample word width
    localparam int N           = 8;    // points per 1-D transform
    localparam int LEVEL_SHIFT = 128;  // offset added to each output word when level shift is on
    localparam int PIX_MAX     = 255;  // upper clamp of a level-shifted word

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROW   = 2'd1,
        ST_COL   = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/idct_tbuf.sv
// N x N transpose buffer: a whole row is written per cycle, a whole column
// is read combinationally. Contents are deliberately not reset; the
// controller always rewrites every row before any column is read out.
module idct_tbuf
#(
    parameter int W = 32,
    parameter int N = 8
)
(
    input  logic                   clk,
    input  logic                   wr_en_i,
    input  logic [$clog2(N)-1:0]   wr_row_i,
    input  logic [N*W-1:0]         wr_data_i,
    input  logic [$clog2(N)-1:0]   rd_col_i,
    output logic [N*W-1:0]         rd_data_o
);

    import idct_pkg::*;

    logic [W-1:0] mem_q [N][N];

    // Row write: word k of the incoming vector lands in column k of the selected row.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int k = 0; k < N; k++) begin
                mem_q[wr_row_i][k] <= wr_data_i[k*W +: W];
            end
        end
    end

    // Column read: word k of the output vector is row k of the selected column.
    always_comb begin
        rd_data_o = '0;
        for (int k = 0; k < N; k++) begin
            rd_data_o[k*W +: W] = mem_q[k][rd_col_i];
        end
    end

endmodule

// File: rtl/idct_2d_ctrl.sv
// Row/column controller for a 2-D IDCT built around one external
// combinational 1-D datapath. Rows are transformed on the way into a
// transpose buffer; columns are then read back, transformed again and
// handed out one per valid/ready handshake.
// Optional feature: define IDCT_CTRL_LEVEL_SHIFT_EN to add 128 to each
// output word and clamp it to [0,255].
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for row 0 of a new block, in_ready=1
// ST_ROW   | accepting rows 1..N-1, each transformed into the buffer
// ST_COL   | transforming buffer column cnt, result registered to out_col
// ST_DRAIN | holding out_col/out_valid until the consumer takes it
module idct_2d_ctrl
#(
    parameter int W = idct_pkg::W,
    parameter int N = idct_pkg::N
)
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_row,
    output logic [N*W-1:0] dp_in,
    input  logic [N*W-1:0] dp_out,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_col,
    output logic           busy
);

    import idct_pkg::*;

    localparam int             CW       = $clog2(N);
    localparam logic [CW-1:0]  CNT_LAST = CW'(N - 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;
    logic [N*W-1:0]  out_col_q, out_col_d;
    logic            wr_en;
    logic [CW-1:0]   wr_row;
    logic [N*W-1:0]  col_rd;
    logic [N*W-1:0]  col_res;

    idct_tbuf #(.W(W), .N(N)) u_tbuf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_row_i  (wr_row),
        .wr_data_i (dp_out),
        .rd_col_i  (cnt_q),
        .rd_data_o (col_rd)
    );

    // Datapath operand: the incoming row while loading, the buffered column while reading out.
    assign dp_in    = (state_q == ST_COL) ? col_rd : in_row;
    assign in_ready = (state_q == ST_IDLE) || (state_q == ST_ROW);
    assign busy     = (state_q != ST_IDLE);
    assign out_valid = out_valid_q;
    assign out_col   = out_col_q;

`ifdef IDCT_CTRL_LEVEL_SHIFT_EN
    function automatic logic [W-1:0] shift_word(input logic [W-1:0] x);
        logic signed [W:0] s;
        s = $signed({x[W-1], x}) + $signed((W+1)'(LEVEL_SHIFT));
        if (s < 0)
            return '0;
        else if (s > $signed((W+1)'(PIX_MAX)))
            return W'(PIX_MAX);
        else
            return s[W-1:0];
    endfunction

    // Level-shift and clamp every word of the column result.
    always_comb begin
        col_res = '0;
        for (int k = 0; k < N; k++) begin
            col_res[k*W +: W] = shift_word(dp_out[k*W +: W]);
        end
    end
`else
    // Column result passes through unmodified.
    always_comb begin
        col_res = dp_out;
    end
`endif

    // Next-state, counter and output-register logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_col_d   = out_col_q;
        wr_en       = 1'b0;
        wr_row      = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    wr_en   = 1'b1;
                    wr_row  = '0;
                    cnt_d   = CW'(1);
                    state_d = ST_ROW;
                end
            end
            ST_ROW: begin
                if (in_valid) begin
                    wr_en = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_COL;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_COL: begin
                out_col_d   = col_res;
                out_valid_d = 1'b1;
                state_d     = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                        state_d = ST_COL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_col_q   <= out_col_d;
        end
    end

endmodule

// File: tb/tb_idct_2d_ctrl.sv
// Directed bench for idct_2d_ctrl with an identity 1-D datapath.
// Honours IDCT_CTRL_LEVEL_SHIFT_EN when computing expected output words.
module tb_idct_2d_ctrl;

    localparam int W = 32;
    localparam int N = 8;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_row;
    logic [N*W-1:0] dp_in;
    logic [N*W-1:0] dp_out;
    logic           out_valid;
    logic           out_ready;
    logic [N*W-1:0] out_col;
    logic           busy;

    int n_checks = 0;
    int n_errors = 0;
    int blk [N][N];

    idct_2d_ctrl #(.W(W), .N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .dp_in     (dp_in),
        .dp_out    (dp_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .busy      (busy)
    );

    assign dp_out = dp_in;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, $signed(obs), $signed(exp), $time);
        end
    endtask

    function automatic logic [31:0] exp_word(input int v);
`ifdef IDCT_CTRL_LEVEL_SHIFT_EN
        int s;
        s = v + 128;
        if (s < 0) return 32'd0;
        if (s > 255) return 32'd255;
        return 32'(s);
`else
        return 32'(v);
`endif
    endfunction

    task automatic send_rows(input int nrows, input int gap);
        for (int r = 0; r < nrows; r++) begin
            in_valid = 1'b1;
            for (int k = 0; k < N; k++) in_row[k*W +: W] = 32'(blk[r][k]);
            chk("in_ready_row", 32'(in_ready), 1);
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_row   = '0;
            if (r < nrows - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                end
            end
        end
    endtask

    task automatic recv_cols(input int stall_col, input int stall_n);
        logic [N*W-1:0] snap;
        int t;
        for (int c = 0; c < N; c++) begin
            t = 0;
            while (out_valid !== 1'b1 && t < 10) begin
                @(posedge clk); #1;
                t++;
            end
            chk("out_valid_seen", 32'(out_valid), 1);
            chk("col_rate", 32'(t), (c == 0) ? 0 : 1);
            if (c == stall_col) begin
                out_ready = 1'b0;
                snap = out_col;
                for (int s = 0; s < stall_n; s++) begin
                    @(posedge clk); #1;
                    chk("stall_valid", 32'(out_valid), 1);
                    chk("stall_busy", 32'(busy), 1);
                    chk("stall_stable", 32'(out_col == snap), 1);
                end
                out_ready = 1'b1;
            end
            for (int r = 0; r < N; r++) begin
                chk($sformatf("col%0d_word%0d", c, r), out_col[r*W +: W], exp_word(blk[r][c]));
            end
            @(posedge clk); #1;
            if (c < N - 1) chk("out_valid_drop", 32'(out_valid), 0);
        end
        chk("idle_busy", 32'(busy), 0);
        chk("idle_in_ready", 32'(in_ready), 1);
        chk("idle_out_valid", 32'(out_valid), 0);
    endtask

    task automatic run_block(input int gap, input int stall_col, input int stall_n);
        send_rows(N, gap);
        chk("lat_cycle1_valid", 32'(out_valid), 0);
        chk("col_in_ready", 32'(in_ready), 0);
        chk("col_busy", 32'(busy), 1);
        @(posedge clk); #1;
        chk("lat_cycle2_valid", 32'(out_valid), 1);
        chk("drain_in_ready", 32'(in_ready), 0);
        recv_cols(stall_col, stall_n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_col_zero", 32'(out_col == '0), 1);
        chk("rst_busy", 32'(busy), 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 32'(in_ready), 1);
        chk("post_rst_busy", 32'(busy), 0);

        // All-zero block.
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) blk[r][k] = 0;
        run_block(0, -1, 0);

        // Ramp block, gap-free.
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) blk[r][k] = 8*r + k;
        run_block(0, -1, 0);

        // Same ramp with 3-cycle gaps between rows.
        run_block(3, -1, 0);

        // Different data with a 5-cycle stall on column 3.
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) blk[r][k] = 1000 + 16*r + 3*k;
        run_block(0, 3, 5);

        // Reset after row 4 of a partial block, then a fresh block.
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) blk[r][k] = 5000 + r;
        send_rows(5, 0);
        chk("mid_busy", 32'(busy), 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_out_valid", 32'(out_valid), 0);
        chk("midrst_in_ready", 32'(in_ready), 1);
        rst_n = 1'b1;
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) blk[r][k] = 7000 + 10*r + k;
        run_block(0, -1, 0);

        // Signed and clamp-boundary values.
        for (int r = 0; r < N; r++) for (int k = 0; k < N; k++) blk[r][k] = (r - 4) * 90 + k * 7;
        blk[0][0] = -300; blk[1][0] = 100; blk[2][0] = 200; blk[3][0] = -1;
        blk[4][0] = -128; blk[5][0] = 127; blk[6][0] = 128; blk[7][0] = -129;
        run_block(1, 0, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/idct_2d_ctrl.md
IDCT_2D_CTRL -- requirements
Module: idct_2d_ctrl

Interface
REQ-001 Parameter W, 32, width of one coefficient/sample word.
REQ-002 Parameter N, 8, points per 1-D transform and rows/columns per block.
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_valid  input  1  in_row carries one valid coefficient row.
REQ-006 in_ready  output  1  block accepts in_row this cycle.
REQ-007 in_row  input  N*W  row of coefficients, word k at bits [k*W +: W].
REQ-008 dp_in  output  N*W  operand vector driven to the external combinational 1-D IDCT datapath.
REQ-009 dp_out  input  N*W  datapath result for dp_in, valid in the same cycle.
REQ-010 out_valid  output  1  out_col holds one valid result column.
REQ-011 out_ready  input  1  consumer accepts out_col this cycle.
REQ-012 out_col  output  N*W  one result column, word k = row k.
REQ-013 busy  output  1  high in any state other than IDLE.

Function
REQ-014 FSM states: IDLE, ROW, COL, DRAIN; 3-bit counter cnt indexes row or column.
REQ-015 IDLE: in_ready=1; an accepted row (in_valid & in_ready) is processed as row 0 and moves the FSM to ROW with cnt=1.
REQ-016 ROW: in_ready=1; dp_in=in_row; each accepted row writes dp_out into row cnt of an internal N x N transpose buffer, then cnt increments.
REQ-017 ROW to COL occurs on acceptance of row N-1; cnt resets to 0; in_ready=0 from the next cycle.
REQ-018 In ROW, cycles with in_valid=0 cause no state, counter or buffer change.
REQ-019 COL: dp_in = column cnt of the transpose buffer; dp_out is registered into out_col with out_valid=1; FSM moves to DRAIN.
REQ-020 DRAIN: out_col and out_valid hold stable until out_ready=1; on acceptance, cnt increments and FSM returns to COL, or to IDLE after column N-1.
REQ-021 Latency: first out_valid exactly 2 cycles after acceptance of row N-1.
REQ-022 Throughput: one row per cycle in ROW; one column per 2 cycles in COL/DRAIN with out_ready held high.
REQ-023 in_ready=0 in COL and DRAIN; a new block is accepted only after returning to IDLE (no overlap).
REQ-024 Arithmetic: W-bit two's-complement words passed unmodified between datapath and buffer; no width growth.
REQ-025 out_ready asserted while out_valid=0 has no effect.

Reset
REQ-026 While rst_n=0 at a clock edge: FSM=IDLE, cnt=0, out_valid=0, out_col=0, busy=0; in_ready=1 from the first cycle after reset.
REQ-027 Reset in mid-block discards the partial block; transpose buffer contents are not cleared and are never output before being rewritten.

Configuration
REQ-028 Macro IDCT_CTRL_LEVEL_SHIFT_EN defined: each out_col word = saturate(dp_out word + 128) to the range [0,255], zero-extended to W.
REQ-029 Macro not defined: out_col words equal dp_out words unmodified.

Structure
REQ-030 Shared package idct_pkg holds W, N, the FSM state enum and the level-shift constant 128.
REQ-031 One sub-module, idct_tbuf: N x N x W transpose buffer with a row-write port and a combinational column-read port.

Verification
REQ-032 Scenario: 8 rows, each all-zero, datapath as identity -> 8 columns of zeros; macro off gives 0, macro on gives 128 per word.
REQ-033 Scenario: row r word k = 8*r+k, identity datapath, out_ready=1 -> column c word r = 8*r+c, out_valid first high 2 cycles after row 7.
REQ-034 Scenario: out_ready low for 5 cycles on column 3 -> out_col stable, no column skipped or repeated, busy stays 1.
REQ-035 Scenario: in_valid gaps of 3 cycles between rows -> cnt and output identical to gap-free run.
REQ-036 Scenario: rst_n=0 after row 4 -> next cycle IDLE, out_valid=0, then a fresh 8-row block outputs only new data.
REQ-037 Scenario, macro on: dp_out word -300 gives 0; 100 gives 228; 200 gives 255.
